// File: rtl/bigblade_tag_tx_pkg.sv
// ============================================================================
//  Module : bigblade_tag_tx_pkg
//  Desc   : Shared types and default sizing for the bsg_tag packet transmitter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bigblade_tag_tx_pkg;

    localparam int c_TAG_ELS      = 512;
    localparam int c_TAG_LG_WIDTH = 4;
    localparam int c_GAP          = 4;
    localparam int c_RESET_ONES   = 32;
    localparam int c_ID_W         = (c_TAG_ELS > 1) ? $clog2(c_TAG_ELS) : 1;
    localparam int c_PAYLOAD_W    = (1 << c_TAG_LG_WIDTH) - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        RST1    = 3'd3,
        GAP     = 3'd4
    } state_e;

    // Header fields in wire order from MSB down; the start bit sits below len.
    typedef struct packed {
        logic [c_ID_W-1:0]         node_id;
        logic                      data_not_reset;
        logic [c_TAG_LG_WIDTH-1:0] len;
    } tag_header_s;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bigblade_tag_tx_piso.sv
// ============================================================================
//  Module : bigblade_tag_tx_piso
//  Desc   : Loadable parallel-in/serial-out shift register, LSB first.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bigblade_tag_tx_piso
    import bigblade_tag_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] r_q;

    // bit_o is the bit consumed at the next edge when shift_i is high;
    // load_i with shift_i consumes data_i[0] in the same cycle it loads.
    assign bit_o = load_i ? data_i[0] : r_q[0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_q <= '0;
        end else if (load_i) begin
            r_q <= shift_i ? (data_i >> 1) : data_i;
        end else if (shift_i) begin
            r_q <= r_q >> 1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bigblade_tag_tx.sv
// ============================================================================
//  Module : bigblade_tag_tx
//  Desc   : bsg_tag serial packet transmitter with master-reset pattern.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bigblade_tag_tx
    import bigblade_tag_tx_pkg::*;
#(
    parameter  int TAG_ELS_P      = c_TAG_ELS,
    parameter  int TAG_LG_WIDTH_P = c_TAG_LG_WIDTH,
    parameter  int GAP_P          = c_GAP,
    parameter  int RESET_ONES_P   = c_RESET_ONES,
    localparam int c_IDW          = (TAG_ELS_P > 1) ? $clog2(TAG_ELS_P) : 1,
    localparam int c_PLW          = (1 << TAG_LG_WIDTH_P) - 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    output logic                      ready_o,
    input  logic                      reset_cmd_i,
    input  logic [c_IDW-1:0]          node_id_i,
    input  logic                      data_not_reset_i,
    input  logic [TAG_LG_WIDTH_P-1:0] len_i,
    input  logic [c_PLW-1:0]          payload_i,
    output logic                      tag_data_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int c_HDR_W   = c_IDW + TAG_LG_WIDTH_P + 2;
    localparam int c_CNT_MAX = max3(RESET_ONES_P, c_HDR_W, GAP_P);
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0] c_HDR_LAST = c_CW'(c_HDR_W - 1);
    localparam logic [c_CW-1:0] c_RST_LAST = c_CW'(RESET_ONES_P - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST = c_CW'(GAP_P - 1);
    localparam logic            c_GAP_ONE  = (GAP_P == 1);

    state_e                    r_state;
    logic [c_CW-1:0]           r_cnt;
    logic [TAG_LG_WIDTH_P-1:0] r_len;

    logic w_accept;
    logic w_hdr_load;
    logic w_hdr_shift;
    logic w_pay_shift;
    logic w_pay_last;
    logic w_hdr_bit;
    logic w_pay_bit;

    assign w_accept = v_i & ready_o;

    always_comb begin
        w_hdr_load  = w_accept & ~reset_cmd_i;
        w_pay_last  = (r_cnt == (c_CW'(r_len) - c_CW'(1)));
        w_hdr_shift = w_hdr_load |
                      ((r_state == HDR) && (r_cnt != c_HDR_LAST));
        w_pay_shift = ((r_state == HDR) && (r_cnt == c_HDR_LAST) && (r_len != '0)) |
                      ((r_state == PAYLOAD) && !w_pay_last);
    end

    bigblade_tag_tx_piso #(
        .WIDTH (c_HDR_W)
    ) u_hdr_piso (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (w_hdr_load),
        .shift_i   (w_hdr_shift),
        .data_i    ({node_id_i, data_not_reset_i, len_i, 1'b1}),
        .bit_o     (w_hdr_bit)
    );

    bigblade_tag_tx_piso #(
        .WIDTH (c_PLW)
    ) u_pay_piso (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (w_hdr_load),
        .shift_i   (w_pay_shift),
        .data_i    (payload_i),
        .bit_o     (w_pay_bit)
    );

    // r_cnt always indexes the bit currently on tag_data_o within its field.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            tag_data_o <= 1'b0;
            ready_o    <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    tag_data_o <= 1'b0;
                    if (w_accept) begin
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                        r_cnt   <= '0;
                        if (reset_cmd_i) begin
                            r_state    <= RST1;
                            tag_data_o <= 1'b1;
                        end else begin
                            r_state    <= HDR;
                            r_len      <= len_i;
                            tag_data_o <= w_hdr_bit;
                        end
                    end
                end
                HDR: begin
                    if (r_cnt == c_HDR_LAST) begin
                        r_cnt <= '0;
                        if (r_len == '0) begin
                            r_state    <= GAP;
                            tag_data_o <= 1'b0;
                            done_o     <= c_GAP_ONE;
                        end else begin
                            r_state    <= PAYLOAD;
                            tag_data_o <= w_pay_bit;
                        end
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        tag_data_o <= w_hdr_bit;
                    end
                end
                PAYLOAD: begin
                    if (w_pay_last) begin
                        r_state    <= GAP;
                        r_cnt      <= '0;
                        tag_data_o <= 1'b0;
                        done_o     <= c_GAP_ONE;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        tag_data_o <= w_pay_bit;
                    end
                end
                RST1: begin
                    if (r_cnt == c_RST_LAST) begin
                        r_state    <= GAP;
                        r_cnt      <= '0;
                        tag_data_o <= 1'b0;
                        done_o     <= c_GAP_ONE;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        tag_data_o <= 1'b1;
                    end
                end
                GAP: begin
                    tag_data_o <= 1'b0;
                    if (r_cnt == c_GAP_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        done_o <= ((r_cnt + 1'b1) == c_GAP_LAST);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cnt      <= '0;
                    tag_data_o <= 1'b0;
                    ready_o    <= 1'b1;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bigblade_tag_tx.sv
// ============================================================================
//  Module : tb_bigblade_tag_tx
//  Desc   : Directed self-checking bench for bigblade_tag_tx.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bigblade_tag_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        v;
    logic        ready;
    logic        reset_cmd;
    logic [8:0]  node_id;
    logic        dnr;
    logic [3:0]  len;
    logic [14:0] payload;
    logic        tag_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] cap_bits;
    int           done_at;
    int           done_cnt;
    int           ready_at;
    int           busy_cnt;

    always #5 clk = ~clk;

    bigblade_tag_tx dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .v_i              (v),
        .ready_o          (ready),
        .reset_cmd_i      (reset_cmd),
        .node_id_i        (node_id),
        .data_not_reset_i (dnr),
        .len_i            (len),
        .payload_i        (payload),
        .tag_data_o       (tag_data),
        .busy_o           (busy),
        .done_o           (done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One handshake, then ncap cycles of tag_data captured LSB = first cycle after accept.
    task automatic send_pkt(input logic rc, input logic [8:0] nid, input logic d,
                            input logic [3:0] l, input logic [14:0] p, input int ncap);
        @(negedge clk);
        v = 1'b1; reset_cmd = rc; node_id = nid; dnr = d; len = l; payload = p;
        @(posedge clk);
        #1;
        v = 1'b0; reset_cmd = ~rc; node_id = ~nid; dnr = ~d; len = ~l; payload = ~p;
        cap_bits = '0; done_at = 0; done_cnt = 0; ready_at = 0; busy_cnt = 0;
        for (int c = 1; c <= ncap; c++) begin
            @(negedge clk);
            cap_bits[c-1] = tag_data;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (busy) busy_cnt++;
            if (ready && ready_at == 0) ready_at = c;
        end
    endtask

    initial begin
        int k;
        int ones;
        int dones;
        int not_ready;
        logic [127:0] exp5;

        reset_n = 1'b0; v = 1'b0; reset_cmd = 1'b0; node_id = '0; dnr = 1'b0;
        len = '0; payload = '0;
        repeat (3) @(negedge clk);
        chk("rst_tag", 128'(tag_data), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 128'(ready), 128'd1);

        // Idle for 50 cycles: line low, always ready, no done pulse.
        ones = 0; dones = 0; not_ready = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tag_data) ones++;
            if (done) dones++;
            if (!ready) not_ready++;
        end
        chk("idle_ones", 128'(ones), 128'd0);
        chk("idle_done", 128'(dones), 128'd0);
        chk("idle_notready", 128'(not_ready), 128'd0);

        // node 5, dnr 1, len 2, payload 2'b10
        send_pkt(1'b0, 9'd5, 1'b1, 4'd2, 15'b10, 24);
        chk("p2_bits", cap_bits, 128'h10165);
        chk("p2_done_at", 128'(done_at), 128'd21);
        chk("p2_done_cnt", 128'(done_cnt), 128'd1);
        chk("p2_ready_at", 128'(ready_at), 128'd22);
        chk("p2_busy_cnt", 128'(busy_cnt), 128'd21);

        // len 0, node 511, dnr 0: payload must not appear
        send_pkt(1'b0, 9'd511, 1'b0, 4'd0, 15'h7FFF, 22);
        chk("p3_bits", cap_bits, 128'h7FC1);
        chk("p3_done_at", 128'(done_at), 128'd19);
        chk("p3_ready_at", 128'(ready_at), 128'd20);

        // master-reset pattern
        send_pkt(1'b1, 9'd77, 1'b1, 4'd9, 15'h1234, 40);
        chk("rc_bits", cap_bits, 128'hFFFF_FFFF);
        chk("rc_done_at", 128'(done_at), 128'd36);
        chk("rc_ready_at", 128'(ready_at), 128'd37);

        // maximum payload length
        send_pkt(1'b0, 9'd0, 1'b1, 4'd15, 15'h2B3C, 36);
        chk("max_bits", cap_bits, 128'h3F | (128'h2B3C << 15));
        chk("max_done_at", 128'(done_at), 128'd34);

        // v held high across three packets; fields scrambled while busy
        @(negedge clk);
        v = 1'b1; reset_cmd = 1'b0; node_id = 9'd3; dnr = 1'b1; len = 4'd1; payload = 15'h1;
        k = 1; dones = 0; cap_bits = '0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            cap_bits[c] = tag_data;
            if (done) dones++;
            if (ready) begin
                reset_cmd = 1'b0;
                if (k == 1) begin
                    node_id = 9'd256; dnr = 1'b0; len = 4'd3; payload = 15'b101;
                end else if (k == 2) begin
                    node_id = 9'd0; dnr = 1'b1; len = 4'd0; payload = 15'h7FFF;
                end else begin
                    v = 1'b0;
                end
                k++;
            end else begin
                reset_cmd = 1'b1; node_id = 9'h1AA; dnr = 1'b0; len = 4'd7; payload = 15'h5555;
            end
        end
        v = 1'b0; reset_cmd = 1'b0;
        // Start bits are 21 and 44 cycles apart: packet, gap_p zeros, then the accept cycle.
        exp5 = 128'h80E3 | (128'h2C007 << 21) | (128'h21 << 44);
        chk("q_stream", cap_bits, exp5);
        chk("q_dones", 128'(dones), 128'd3);

        // reset in mid-payload
        @(negedge clk);
        v = 1'b1; reset_cmd = 1'b0; node_id = 9'd9; dnr = 1'b1; len = 4'd15; payload = 15'h7FFF;
        @(posedge clk);
        #1;
        v = 1'b0;
        repeat (18) @(negedge clk);
        chk("mid_tag_pre", 128'(tag_data), 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_tag_async", 128'(tag_data), 128'd0);
        chk("mid_busy_async", 128'(busy), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_ready_rel", 128'(ready), 128'd1);
        send_pkt(1'b1, 9'd0, 1'b0, 4'd0, 15'h0, 40);
        chk("mid_rc_bits", cap_bits, 128'hFFFF_FFFF);
        send_pkt(1'b0, 9'd5, 1'b1, 4'd2, 15'b10, 24);
        chk("mid_p_bits", cap_bits, 128'h10165);
        chk("mid_p_done_at", 128'(done_at), 128'd21);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
